branch_outcome_checker: RTL and testbench
=========================================

Name: branch_outcome_checker

Overview:
- Resolution-side partner of the pshare predictor: consumes its `prediction`/`predicted_PC` stream and the same branch trace (`was_branch`, `branch_result`, `next_PC`, `direction`).
- Re-aligns the trace to the predictor's PRED_LAT-cycle output latency and grades each branch on direction and target.
- Emits a mispredict/flush pulse carrying the corrected PC.
- Keeps saturating accuracy counters under a start/stop/drain measurement FSM.

Parameters:
- Direction_SIZE, 32, width of the address, PC and PC-arithmetic fields.
- PRED_LAT, 2, cycles from a trace entry at the inputs to its matching prediction at the inputs; legal 1..8.
- CNT_W, 32, width of every statistics counter.
- INSTR_BYTES, 4, fall-through increment added to `direction` for not-taken branches.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  one-cycle pulse: clear counters and begin measuring.
- stop  in  1  one-cycle pulse: stop accepting new trace entries, then drain.
- was_branch  in  1  trace: current entry is a branch.
- branch_result  in  1  trace: actual outcome, 1 = taken.
- next_PC  in  Direction_SIZE  trace: actual taken target.
- direction  in  Direction_SIZE  trace: branch address.
- prediction  in  1  predictor output for the entry PRED_LAT cycles earlier.
- predicted_PC  in  Direction_SIZE  predictor target for that same entry.
- mispredict  out  1  one-cycle pulse on a graded miss.
- flush_PC  out  Direction_SIZE  corrected PC; valid when mispredict = 1.
- total_branch  out  CNT_W  branches graded.
- dir_miss  out  CNT_W  direction mismatches.
- target_miss  out  CNT_W  target mismatches on correctly predicted taken branches.
- max_streak  out  CNT_W  longest run of consecutive graded misses.
- busy  out  1  FSM in RUN or DRAIN.
- done  out  1  one-cycle pulse on entering DONE.

Behaviour:
- **Reset:**
  - All outputs are 0, FSM = IDLE, delay line cleared (all valid bits 0).
  - Applies asynchronously, including mid-RUN or mid-DRAIN; nothing is preserved.
- **Delay line:**
  - PRED_LAT-stage shift register of {valid, taken, next_PC, direction}.
  - Stage 0 is loaded every cycle with valid = was_branch AND (state == RUN).
  - The last stage lines up with the prediction/predicted_PC sampled in the same cycle.
- **Grading** (registered; results appear one cycle after the last stage and the prediction coincide), performed only when the last stage is valid:
  - dmiss = (prediction != taken).
  - tmiss = taken AND prediction AND (predicted_PC != next_PC).
  - miss = dmiss OR tmiss.
  - total_branch +1 per graded entry.
  - dir_miss +1 on dmiss.
  - target_miss +1 on tmiss; dmiss and tmiss never count together.
  - On miss:
    - mispredict = 1 for exactly one cycle.
    - flush_PC = taken ? next_PC : direction + INSTR_BYTES, modulo 2^Direction_SIZE.
  - Otherwise mispredict = 0 and flush_PC holds its last value.
- **Streak tracking:**
  - Internal streak counter: +1 on miss, reset to 0 on a graded hit.
  - Ungraded cycles leave it unchanged.
  - max_streak updates to streak+1 whenever that exceeds it.
- **Counter width:** all counters saturate at 2^CNT_W−1; no wrap.
- **FSM (IDLE, RUN, DRAIN, DONE):**
  - IDLE: start → RUN; counters, streak and max_streak cleared that same edge.
  - RUN:
    - stop → DRAIN, with a drain counter loaded to PRED_LAT.
    - start is ignored.
    - If start and stop coincide, stop wins.
  - DRAIN:
    - No new valid entries; in-flight entries are still graded.
    - Drain counter decrements each cycle; at 0 → DONE.
    - start and stop are ignored.
  - DONE: done pulses one cycle, counters hold, state returns to IDLE next cycle.
  - busy = 1 in RUN and DRAIN only.
  - Counters remain readable in IDLE until the next start.
- **Inputs outside RUN:**
  - was_branch outside RUN is ignored.
  - prediction inputs are graded only when paired with a valid stage.

Test Plan:
- **Reset mid-run:** reset=0 mid-RUN with entries in flight → all outputs 0 within the same cycle, busy = 0; first grade after start + PRED_LAT + 1 cycles.
- **Direction hit/miss:** PRED_LAT=2; start, then branch dir=0x100, taken=1, next_PC=0x200; two cycles later prediction=0.
  - mispredict pulse with flush_PC=0x200, dir_miss=1, total_branch=1.
- **Target miss:** taken=1, next_PC=0xBBBB; prediction=1, predicted_PC=0xAAAA → target_miss=1, dir_miss=0, flush_PC=0xBBBB.
- **Not-taken flush and wrap:** dir=0xFFFFFFFC, taken=0, prediction=1 → flush_PC=0x00000000.
- **Streaks:** miss pattern M,M,M,H,M → max_streak=3, dir_miss=4, total_branch=5.
- **Drain and saturation:** stop with 2 entries in flight → both graded, done pulses PRED_LAT+1 cycles after stop, busy falls.
  - With CNT_W=4: 20 misses → dir_miss=15.

Source files
------------

// File: rtl/branch_outcome_checker.sv
// -----------------------------------------------------------------------------
// branch_outcome_checker
//
// Resolution-side partner of the pshare predictor. It delays the branch trace
// by PRED_LAT cycles so that each entry meets the prediction produced for it,
// grades the pair on direction and target, raises a one-cycle mispredict with
// the corrected PC, and keeps saturating accuracy statistics while a
// start/stop/drain measurement FSM is active.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous active-low reset, clears all state
//   start          pulse: clear statistics and begin measuring (IDLE only)
//   stop           pulse: stop accepting trace entries, then drain (RUN only)
//   was_branch     trace: current entry is a branch
//   branch_result  trace: actual outcome, 1 = taken
//   next_PC        trace: actual taken target
//   direction      trace: branch address
//   prediction     predictor direction for the entry PRED_LAT cycles earlier
//   predicted_PC   predictor target for that same entry
//   mispredict     one-cycle pulse on a graded miss
//   flush_PC       corrected PC, valid while mispredict is high
//   total_branch   number of graded branches
//   dir_miss       number of direction mismatches
//   target_miss    number of wrong targets on correctly predicted taken branches
//   max_streak     longest run of consecutive graded misses
//   busy           FSM is in RUN or DRAIN
//   done           one-cycle pulse while the FSM sits in DONE
// -----------------------------------------------------------------------------
module branch_outcome_checker #(
   parameter int Direction_SIZE = 32,
   parameter int PRED_LAT       = 2,
   parameter int CNT_W          = 32,
   parameter int INSTR_BYTES    = 4
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      start,
   input  logic                      stop,
   input  logic                      was_branch,
   input  logic                      branch_result,
   input  logic [Direction_SIZE-1:0] next_PC,
   input  logic [Direction_SIZE-1:0] direction,
   input  logic                      prediction,
   input  logic [Direction_SIZE-1:0] predicted_PC,
   output logic                      mispredict,
   output logic [Direction_SIZE-1:0] flush_PC,
   output logic [CNT_W-1:0]          total_branch,
   output logic [CNT_W-1:0]          dir_miss,
   output logic [CNT_W-1:0]          target_miss,
   output logic [CNT_W-1:0]          max_streak,
   output logic                      busy,
   output logic                      done
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   // The drain counter must be able to hold PRED_LAT itself.
   localparam int              DCW        = $clog2(PRED_LAT + 1);
   localparam logic [DCW-1:0]  DRAIN_INIT = DCW'(PRED_LAT);

   typedef struct packed {
      logic                      vld;
      logic                      tkn;
      logic [Direction_SIZE-1:0] npc;
      logic [Direction_SIZE-1:0] addr;
   } stage_t;

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   // ---------------------------------------------------------------------------
   // Measurement FSM
   // ---------------------------------------------------------------------------
   logic [1:0]     state_q, state_d;
   logic [DCW-1:0] drain_q, drain_d;
   logic           clear_stats;

   // NOTE: every signal driven here gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      clear_stats = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d     = S_RUN;
               clear_stats = 1'b1;
            end
         end
         S_RUN: begin
            // start is ignored here, so a coincident start/stop resolves to stop.
            if (stop) begin
               state_d = S_DRAIN;
               drain_d = DRAIN_INIT;
            end
         end
         S_DRAIN: begin
            if (drain_q == '0) state_d = S_DONE;
            else               drain_d = drain_q - DCW'(1);
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         drain_q <= '0;
      end else begin
         state_q <= state_d;
         drain_q <= drain_d;
      end
   end

   assign busy = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign done = (state_q == S_DONE);

   // ---------------------------------------------------------------------------
   // Trace delay line: the last stage lines up with the prediction inputs.
   // ---------------------------------------------------------------------------
   stage_t pipe_q [PRED_LAT];
   stage_t stage_in;
   stage_t last;

   always_comb begin
      stage_in.vld  = was_branch && (state_q == S_RUN);
      stage_in.tkn  = branch_result;
      stage_in.npc  = next_PC;
      stage_in.addr = direction;
   end

   // NOTE: the delay line is a storage array but is still reset: stale valid
   // bits surviving a reset would be graded as phantom branches.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < PRED_LAT; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= stage_in;
         for (int i = 1; i < PRED_LAT; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   assign last = pipe_q[PRED_LAT-1];

   // ---------------------------------------------------------------------------
   // Grading
   // ---------------------------------------------------------------------------
   logic                      dmiss, tmiss, miss;
   logic [Direction_SIZE-1:0] fall_thru;

   // A target is only judged when both sides agree the branch was taken, so a
   // single entry can never count as both a direction and a target miss.
   assign dmiss     = last.vld && (prediction != last.tkn);
   assign tmiss     = last.vld && last.tkn && prediction && (predicted_PC != last.npc);
   assign miss      = dmiss || tmiss;
   assign fall_thru = last.addr + Direction_SIZE'(INSTR_BYTES);

   logic                      mispredict_q, mispredict_d;
   logic [Direction_SIZE-1:0] flush_q, flush_d;
   logic [CNT_W-1:0]          total_q, total_d;
   logic [CNT_W-1:0]          dmiss_q, dmiss_d;
   logic [CNT_W-1:0]          tmiss_q, tmiss_d;
   logic [CNT_W-1:0]          streak_q, streak_d;
   logic [CNT_W-1:0]          max_q, max_d;

   always_comb begin
      mispredict_d = miss;
      flush_d      = flush_q;
      total_d      = total_q;
      dmiss_d      = dmiss_q;
      tmiss_d      = tmiss_q;
      streak_d     = streak_q;
      max_d        = max_q;

      if (miss) flush_d = last.tkn ? last.npc : fall_thru;

      if (last.vld) begin
         total_d = sat_inc(total_q);
         if (dmiss) dmiss_d = sat_inc(dmiss_q);
         if (tmiss) tmiss_d = sat_inc(tmiss_q);
         if (miss) begin
            streak_d = sat_inc(streak_q);
            if (streak_d > max_q) max_d = streak_d;
         end else begin
            streak_d = '0;
         end
      end

      if (clear_stats) begin
         total_d  = '0;
         dmiss_d  = '0;
         tmiss_d  = '0;
         streak_d = '0;
         max_d    = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mispredict_q <= 1'b0;
         flush_q      <= '0;
         total_q      <= '0;
         dmiss_q      <= '0;
         tmiss_q      <= '0;
         streak_q     <= '0;
         max_q        <= '0;
      end else begin
         mispredict_q <= mispredict_d;
         flush_q      <= flush_d;
         total_q      <= total_d;
         dmiss_q      <= dmiss_d;
         tmiss_q      <= tmiss_d;
         streak_q     <= streak_d;
         max_q        <= max_d;
      end
   end

   assign mispredict   = mispredict_q;
   assign flush_PC     = flush_q;
   assign total_branch = total_q;
   assign dir_miss     = dmiss_q;
   assign target_miss  = tmiss_q;
   assign max_streak   = max_q;

endmodule

// File: tb/tb_branch_outcome_checker.sv
// -----------------------------------------------------------------------------
// tb_branch_outcome_checker
//
// Directed bench for branch_outcome_checker with PRED_LAT = 2. A second
// instance with 4-bit counters shares all inputs and is used to observe
// saturation. Inputs are driven on the falling edge; outputs are sampled on
// the falling edge before new inputs are applied.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_branch_outcome_checker;

   localparam int PL = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        was_branch = 1'b0;
   logic        branch_result = 1'b0;
   logic [31:0] next_PC = '0;
   logic [31:0] direction = '0;
   logic        prediction = 1'b1;
   logic [31:0] predicted_PC = 32'hDEAD;

   logic        mispredict, busy, done;
   logic [31:0] flush_PC, total_branch, dir_miss, target_miss, max_streak;

   logic        sm_mispredict, sm_busy, sm_done;
   logic [31:0] sm_flush;
   logic [3:0]  sm_total, sm_dmiss, sm_tmiss, sm_max;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_flush = '0;

   // stimulus table for run_stream
   logic        st_tk   [32];
   logic [31:0] st_npc  [32];
   logic [31:0] st_dir  [32];
   logic        st_pred [32];
   logic [31:0] st_ppc  [32];
   logic        st_miss [32];
   logic [31:0] st_flush[32];

   always #5 clk = ~clk;

   branch_outcome_checker #(.Direction_SIZE(32), .PRED_LAT(PL), .CNT_W(32), .INSTR_BYTES(4)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .was_branch(was_branch), .branch_result(branch_result),
      .next_PC(next_PC), .direction(direction),
      .prediction(prediction), .predicted_PC(predicted_PC),
      .mispredict(mispredict), .flush_PC(flush_PC),
      .total_branch(total_branch), .dir_miss(dir_miss),
      .target_miss(target_miss), .max_streak(max_streak),
      .busy(busy), .done(done)
   );

   branch_outcome_checker #(.Direction_SIZE(32), .PRED_LAT(PL), .CNT_W(4), .INSTR_BYTES(4)) dut_sm (
      .clk(clk), .reset(reset), .start(start), .stop(stop),
      .was_branch(was_branch), .branch_result(branch_result),
      .next_PC(next_PC), .direction(direction),
      .prediction(prediction), .predicted_PC(predicted_PC),
      .mispredict(sm_mispredict), .flush_PC(sm_flush),
      .total_branch(sm_total), .dir_miss(sm_dmiss),
      .target_miss(sm_tmiss), .max_streak(sm_max),
      .busy(sm_busy), .done(sm_done)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic set_idle();
      start         = 1'b0;
      stop          = 1'b0;
      was_branch    = 1'b0;
      branch_result = 1'b0;
      next_PC       = '0;
      direction     = '0;
      prediction    = 1'b1;          // unpaired predictions must be ignored
      predicted_PC  = 32'hDEAD;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      reset = 1'b0;
      set_idle();
      exp_flush = '0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
   endtask

   // Start pulse; a branch offered in the same IDLE cycle must not be captured.
   task automatic do_start();
      @(negedge clk);
      start         = 1'b1;
      was_branch    = 1'b1;
      branch_result = 1'b1;
      next_PC       = 32'h0;
      direction     = 32'h40;
      @(negedge clk);
      set_idle();
   endtask

   task automatic put(input int i, input logic tk, input logic [31:0] npc, input logic [31:0] dir,
                      input logic pred, input logic [31:0] ppc, input logic ms, input logic [31:0] fl);
      st_tk[i] = tk; st_npc[i] = npc; st_dir[i] = dir;
      st_pred[i] = pred; st_ppc[i] = ppc; st_miss[i] = ms; st_flush[i] = fl;
   endtask

   // Back-to-back entries, each prediction PL cycles after its entry, and each
   // graded result checked one cycle after the pairing.
   task automatic run_stream(input int n);
      for (int k = 0; k <= n + PL; k++) begin
         @(negedge clk);
         if (k >= PL + 1) begin
            int idx;
            idx = k - PL - 1;
            if (st_miss[idx]) exp_flush = st_flush[idx];
            checks++;
            if (mispredict !== st_miss[idx]) begin
               errors++;
               $display("FAIL stream[%0d] mispredict: got %b expected %b", idx, mispredict, st_miss[idx]);
            end
            checks++;
            if (flush_PC !== exp_flush) begin
               errors++;
               $display("FAIL stream[%0d] flush_PC: got %h expected %h", idx, flush_PC, exp_flush);
            end
         end
         if (k < n) begin
            was_branch = 1'b1; branch_result = st_tk[k]; next_PC = st_npc[k]; direction = st_dir[k];
         end else begin
            was_branch = 1'b0; branch_result = 1'b0; next_PC = '0; direction = '0;
         end
         if (k >= PL && k - PL < n) begin
            prediction = st_pred[k-PL]; predicted_PC = st_ppc[k-PL];
         end else begin
            prediction = 1'b1; predicted_PC = 32'hDEAD;
         end
      end
      @(negedge clk);
      set_idle();
      checks++;
      if (mispredict !== 1'b0) begin
         errors++;
         $display("FAIL stream tail mispredict: got %b expected 0", mispredict);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Tests
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      repeat (2) @(negedge clk);
      checks++; if (mispredict !== 1'b0)   begin errors++; $display("FAIL reset mispredict: got %b expected 0", mispredict); end
      checks++; if (flush_PC !== '0)       begin errors++; $display("FAIL reset flush_PC: got %h expected 0", flush_PC); end
      checks++; if (total_branch !== '0)   begin errors++; $display("FAIL reset total_branch: got %0d expected 0", total_branch); end
      checks++; if (dir_miss !== '0)       begin errors++; $display("FAIL reset dir_miss: got %0d expected 0", dir_miss); end
      checks++; if (target_miss !== '0)    begin errors++; $display("FAIL reset target_miss: got %0d expected 0", target_miss); end
      checks++; if (max_streak !== '0)     begin errors++; $display("FAIL reset max_streak: got %0d expected 0", max_streak); end
      checks++; if (busy !== 1'b0)         begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
      checks++; if (done !== 1'b0)         begin errors++; $display("FAIL reset done: got %b expected 0", done); end
      checks++; if ({sm_mispredict, sm_busy, sm_done, sm_total, sm_flush} !== '0) begin
         errors++; $display("FAIL reset small instance: got %h expected 0", {sm_mispredict, sm_busy, sm_done, sm_total, sm_flush});
      end
      reset = 1'b1;
   endtask

   task automatic test_direction();
      apply_reset();
      do_start();
      put(0, 1'b1, 32'h200, 32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
      run_stream(1);
      checks++; if (dir_miss !== 32'd1)     begin errors++; $display("FAIL direction dir_miss: got %0d expected 1", dir_miss); end
      checks++; if (total_branch !== 32'd1) begin errors++; $display("FAIL direction total_branch: got %0d expected 1", total_branch); end
      checks++; if (target_miss !== 32'd0)  begin errors++; $display("FAIL direction target_miss: got %0d expected 0", target_miss); end
      checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL direction busy: got %b expected 1", busy); end
   endtask

   task automatic test_target_miss();
      apply_reset();
      do_start();
      put(0, 1'b1, 32'hBBBB, 32'h300, 1'b1, 32'hAAAA, 1'b1, 32'hBBBB);
      put(1, 1'b1, 32'h500,  32'h400, 1'b1, 32'h500,  1'b0, 32'h0);
      run_stream(2);
      checks++; if (target_miss !== 32'd1)  begin errors++; $display("FAIL target target_miss: got %0d expected 1", target_miss); end
      checks++; if (dir_miss !== 32'd0)     begin errors++; $display("FAIL target dir_miss: got %0d expected 0", dir_miss); end
      checks++; if (total_branch !== 32'd2) begin errors++; $display("FAIL target total_branch: got %0d expected 2", total_branch); end
      checks++; if (max_streak !== 32'd1)   begin errors++; $display("FAIL target max_streak: got %0d expected 1", max_streak); end
   endtask

   task automatic test_not_taken_wrap();
      apply_reset();
      do_start();
      put(0, 1'b1, 32'h600,  32'h500,      1'b0, 32'h0,    1'b1, 32'h600);
      put(1, 1'b0, 32'h1234, 32'hFFFFFFFC, 1'b1, 32'h5555, 1'b1, 32'h0);
      put(2, 1'b0, 32'h7777, 32'h800,      1'b0, 32'h9999, 1'b0, 32'h0);
      run_stream(3);
      checks++; if (dir_miss !== 32'd2)     begin errors++; $display("FAIL wrap dir_miss: got %0d expected 2", dir_miss); end
      checks++; if (target_miss !== 32'd0)  begin errors++; $display("FAIL wrap target_miss: got %0d expected 0", target_miss); end
      checks++; if (total_branch !== 32'd3) begin errors++; $display("FAIL wrap total_branch: got %0d expected 3", total_branch); end
      checks++; if (max_streak !== 32'd2)   begin errors++; $display("FAIL wrap max_streak: got %0d expected 2", max_streak); end
   endtask

   task automatic test_back_to_back_streaks();
      apply_reset();
      do_start();
      put(0, 1'b1, 32'h1000, 32'h10, 1'b0, 32'h0,    1'b1, 32'h1000);
      put(1, 1'b0, 32'h2000, 32'h20, 1'b1, 32'h2000, 1'b1, 32'h24);
      put(2, 1'b1, 32'h3000, 32'h30, 1'b0, 32'h0,    1'b1, 32'h3000);
      put(3, 1'b1, 32'h4000, 32'h40, 1'b1, 32'h4000, 1'b0, 32'h0);
      put(4, 1'b0, 32'h5000, 32'h50, 1'b1, 32'h0,    1'b1, 32'h54);
      run_stream(5);
      checks++; if (max_streak !== 32'd3)   begin errors++; $display("FAIL streak max_streak: got %0d expected 3", max_streak); end
      checks++; if (dir_miss !== 32'd4)     begin errors++; $display("FAIL streak dir_miss: got %0d expected 4", dir_miss); end
      checks++; if (total_branch !== 32'd5) begin errors++; $display("FAIL streak total_branch: got %0d expected 5", total_branch); end
      checks++; if (target_miss !== 32'd0)  begin errors++; $display("FAIL streak target_miss: got %0d expected 0", target_miss); end
   endtask

   task automatic test_drain();
      apply_reset();
      do_start();
      // c0: entry A (will be predicted correctly)
      @(negedge clk);
      was_branch = 1'b1; branch_result = 1'b1; next_PC = 32'h110; direction = 32'h100;
      // c1: entry B, stop together with start (stop wins, B still accepted)
      @(negedge clk);
      was_branch = 1'b1; branch_result = 1'b0; next_PC = 32'h0; direction = 32'h200;
      stop = 1'b1; start = 1'b1;
      // c2: entry C offered in DRAIN (must be dropped); prediction for A
      @(negedge clk);
      stop = 1'b0; start = 1'b0;
      was_branch = 1'b1; branch_result = 1'b1; next_PC = 32'h330; direction = 32'h300;
      prediction = 1'b1; predicted_PC = 32'h110;
      // c3: A graded as hit; prediction for B is wrong; start ignored in DRAIN
      @(negedge clk);
      checks++; if (mispredict !== 1'b0)    begin errors++; $display("FAIL drain A mispredict: got %b expected 0", mispredict); end
      checks++; if (total_branch !== 32'd1) begin errors++; $display("FAIL drain A total_branch: got %0d expected 1", total_branch); end
      checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL drain c3 busy: got %b expected 1", busy); end
      start = 1'b1; was_branch = 1'b0;
      prediction = 1'b1; predicted_PC = 32'h0;
      // c4: B graded as miss, flush is fall-through; C's slot paired with a wrong prediction
      @(negedge clk);
      checks++; if (mispredict !== 1'b1)    begin errors++; $display("FAIL drain B mispredict: got %b expected 1", mispredict); end
      checks++; if (flush_PC !== 32'h204)   begin errors++; $display("FAIL drain B flush_PC: got %h expected 204", flush_PC); end
      checks++; if (total_branch !== 32'd2) begin errors++; $display("FAIL drain B total_branch: got %0d expected 2", total_branch); end
      checks++; if (done !== 1'b0)          begin errors++; $display("FAIL drain c4 done: got %b expected 0", done); end
      checks++; if (busy !== 1'b1)          begin errors++; $display("FAIL drain c4 busy: got %b expected 1", busy); end
      start = 1'b0; prediction = 1'b0; predicted_PC = 32'h0;
      // c5: DONE reached PRED_LAT+1 edges after the stop edge
      @(negedge clk);
      set_idle();
      checks++; if (done !== 1'b1)          begin errors++; $display("FAIL drain done pulse: got %b expected 1", done); end
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL drain c5 busy: got %b expected 0", busy); end
      checks++; if (mispredict !== 1'b0)    begin errors++; $display("FAIL drain C mispredict: got %b expected 0", mispredict); end
      // c6: back in IDLE, counters held
      @(negedge clk);
      checks++; if (done !== 1'b0)          begin errors++; $display("FAIL drain done width: got %b expected 0", done); end
      checks++; if (total_branch !== 32'd2) begin errors++; $display("FAIL drain final total_branch: got %0d expected 2", total_branch); end
      checks++; if (dir_miss !== 32'd1)     begin errors++; $display("FAIL drain final dir_miss: got %0d expected 1", dir_miss); end
   endtask

   task automatic test_saturation();
      int cyc;
      apply_reset();
      do_start();
      for (int i = 0; i < 20; i++)
         put(i, 1'b1, 32'h1000 + 32'(i) * 4, 32'h800 + 32'(i) * 4, 1'b0, 32'h0, 1'b1, 32'h1000 + 32'(i) * 4);
      run_stream(20);
      checks++; if (dir_miss !== 32'd20)    begin errors++; $display("FAIL sat wide dir_miss: got %0d expected 20", dir_miss); end
      checks++; if (max_streak !== 32'd20)  begin errors++; $display("FAIL sat wide max_streak: got %0d expected 20", max_streak); end
      checks++; if (sm_dmiss !== 4'd15)     begin errors++; $display("FAIL sat dir_miss: got %0d expected 15", sm_dmiss); end
      checks++; if (sm_total !== 4'd15)     begin errors++; $display("FAIL sat total_branch: got %0d expected 15", sm_total); end
      checks++; if (sm_max !== 4'd15)       begin errors++; $display("FAIL sat max_streak: got %0d expected 15", sm_max); end
      checks++; if (sm_tmiss !== 4'd0)      begin errors++; $display("FAIL sat target_miss: got %0d expected 0", sm_tmiss); end
      @(negedge clk); stop = 1'b1;
      @(negedge clk); stop = 1'b0;
      cyc = 0;
      while (done !== 1'b1 && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      checks++; if (done !== 1'b1)          begin errors++; $display("FAIL sat done wait: got %b expected 1 within 10 cycles", done); end
      repeat (3) @(negedge clk);
      checks++; if (sm_dmiss !== 4'd15)     begin errors++; $display("FAIL sat idle hold: got %0d expected 15", sm_dmiss); end
      checks++; if (dir_miss !== 32'd20)    begin errors++; $display("FAIL sat idle wide hold: got %0d expected 20", dir_miss); end
      checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL sat idle busy: got %b expected 0", busy); end
   endtask

   task automatic test_reset_mid_run();
      apply_reset();
      do_start();
      put(0, 1'b1, 32'h700, 32'h600, 1'b0, 32'h0, 1'b1, 32'h700);
      run_stream(1);
      // two entries in flight, then an asynchronous reset between edges
      @(negedge clk); was_branch = 1'b1; branch_result = 1'b1; next_PC = 32'hA0; direction = 32'hB0;
      @(negedge clk); was_branch = 1'b1; branch_result = 1'b0; next_PC = 32'hC0; direction = 32'hD0;
      #2 reset = 1'b0;
      #1;
      checks++; if ({mispredict, busy, done} !== 3'b000) begin
         errors++; $display("FAIL midrun flags: got %b expected 000", {mispredict, busy, done});
      end
      checks++; if (flush_PC !== '0)        begin errors++; $display("FAIL midrun flush_PC: got %h expected 0", flush_PC); end
      checks++; if ({total_branch, dir_miss, target_miss, max_streak} !== '0) begin
         errors++; $display("FAIL midrun counters: got %0d/%0d/%0d/%0d expected 0", total_branch, dir_miss, target_miss, max_streak);
      end
      @(negedge clk);
      set_idle();
      exp_flush = '0;
      reset = 1'b1;
      // start edge S, entry in S+1, prediction in S+3, grade visible after edge S+3
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      was_branch = 1'b1; branch_result = 1'b1; next_PC = 32'h900; direction = 32'h800;
      @(negedge clk); set_idle();
      @(negedge clk);
      checks++; if (mispredict !== 1'b0)    begin errors++; $display("FAIL midrun early mispredict: got %b expected 0", mispredict); end
      checks++; if (total_branch !== 32'd0) begin errors++; $display("FAIL midrun early total: got %0d expected 0", total_branch); end
      prediction = 1'b0; predicted_PC = 32'h0;
      @(negedge clk);
      set_idle();
      checks++; if (mispredict !== 1'b1)    begin errors++; $display("FAIL midrun first grade mispredict: got %b expected 1", mispredict); end
      checks++; if (flush_PC !== 32'h900)   begin errors++; $display("FAIL midrun first grade flush_PC: got %h expected 900", flush_PC); end
      checks++; if (total_branch !== 32'd1) begin errors++; $display("FAIL midrun first grade total: got %0d expected 1", total_branch); end
   endtask

   initial begin
      test_reset();
      test_direction();
      test_target_miss();
      test_not_taken_wrap();
      test_back_to_back_streaks();
      test_drain();
      test_saturation();
      test_reset_mid_run();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
